// File: rtl/j1a_boot_arbiter.sv
// -----------------------------------------------------------------------------
// j1a_boot_arbiter
//
// Purpose:
//   Owns the 16-bit program-RAM write port while the j1 core is held in reset.
//   A framed boot image arrives on the UART RX byte stream:
//     SYNC_BYTE, LEN_LO, LEN_HI, N x {DATA_LO, DATA_HI} [, CSUM]
//   Each data word is written little-endian from word address 0 upward.
//   At the end of the frame the core is released and the RAM write port is
//   handed to it through a combinational pass-through.
//
// Optional feature:
//   LOADER_CSUM_EN  When defined, a trailing checksum byte is consumed.
//                   It must equal the XOR of all data bytes.
//                   A mismatch parks the loader in a sticky error state.
//                   When undefined, err is tied low and RUN follows the last data byte.
//
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   rx_valid/data  UART RX byte and its valid flag
//   rx_rd          one-cycle strobe: the byte was consumed by the loader
//   core_mem_*     core RAM write strobe, byte address and data (used in RUN only)
//   ram_*          program-RAM write port (we, word address, data)
//   core_resetq    active-low core reset (0 while loading or in error)
//   busy           high while a frame is being received
//   err            sticky checksum failure
// -----------------------------------------------------------------------------
module j1a_boot_arbiter #(
  parameter int          ADDR_W    = 12,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_rd,
  input  logic              core_mem_wr,
  input  logic [15:0]       core_mem_addr,
  input  logic [15:0]       core_dout,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [15:0]       ram_wdata,
  output logic              core_resetq,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_SYNC,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA_LO,
    S_DATA_HI,
    S_CSUM,
    S_RUN,
    S_ERR
  } state_t;

  // State entered once the last data word (or an empty length) has been taken.
`ifdef LOADER_CSUM_EN
  localparam state_t S_AFTER_DATA = S_CSUM;
`else
  localparam state_t S_AFTER_DATA = S_RUN;
`endif

  state_t              state_q, state_d;
  logic                rx_rd_q, rx_rd_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_waddr_q, ram_waddr_d;
  logic [15:0]         ram_wdata_q, ram_wdata_d;
  logic                core_resetq_q, core_resetq_d;
  logic                busy_q, busy_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         left_q, left_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          lo_q, lo_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
  logic                err_q, err_d;
`endif

  logic                take;
  logic [15:0]         len_word;

  // A byte is taken only when the strobe was low last cycle; this gives the
  // RX source one full cycle to advance to its next byte.
  assign take     = rx_valid && !rx_rd_q && (state_q != S_RUN) && (state_q != S_ERR);
  assign len_word = {rx_data, len_lo_q};

  always_comb begin
    state_d       = state_q;
    rx_rd_d       = 1'b0;
    ram_we_d      = 1'b0;
    ram_waddr_d   = ram_waddr_q;
    ram_wdata_d   = ram_wdata_q;
    core_resetq_d = core_resetq_q;
    len_lo_d      = len_lo_q;
    left_d        = left_q;
    cnt_d         = cnt_q;
    lo_d          = lo_q;
`ifdef LOADER_CSUM_EN
    csum_d        = csum_q;
    err_d         = err_q;
`endif

    case (state_q)
      S_SYNC: begin
        if (take) begin
          rx_rd_d = 1'b1;
          if (rx_data == SYNC_BYTE) begin
            state_d = S_LEN_LO;
          end
        end
      end

      S_LEN_LO: begin
        if (take) begin
          rx_rd_d  = 1'b1;
          len_lo_d = rx_data;
          state_d  = S_LEN_HI;
        end
      end

      S_LEN_HI: begin
        if (take) begin
          rx_rd_d = 1'b1;
          left_d  = len_word;
          cnt_d   = '0;
`ifdef LOADER_CSUM_EN
          csum_d  = 8'h00;
`endif
          state_d = (len_word == 16'd0) ? S_AFTER_DATA : S_DATA_LO;
        end
      end

      S_DATA_LO: begin
        if (take) begin
          rx_rd_d = 1'b1;
          lo_d    = rx_data;
`ifdef LOADER_CSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
          state_d = S_DATA_HI;
        end
      end

      S_DATA_HI: begin
        if (take) begin
          rx_rd_d     = 1'b1;
          ram_we_d    = 1'b1;
          ram_waddr_d = cnt_q;
          ram_wdata_d = {rx_data, lo_q};
          // Address counter wraps naturally for over-long images.
          cnt_d       = cnt_q + 1'b1;
          left_d      = left_q - 16'd1;
`ifdef LOADER_CSUM_EN
          csum_d      = csum_q ^ rx_data;
`endif
          state_d     = (left_q == 16'd1) ? S_AFTER_DATA : S_DATA_LO;
        end
      end

      S_CSUM: begin
`ifdef LOADER_CSUM_EN
        if (take) begin
          rx_rd_d = 1'b1;
          if (rx_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
`else
        state_d = S_RUN;
`endif
      end

      S_RUN: begin
        // Released one cycle after entry so the final loader write is still
        // presented from the loader registers before the port is handed over.
        core_resetq_d = 1'b1;
      end

      default: begin
        // S_ERR: park until reset.
        state_d = S_ERR;
      end
    endcase

    busy_d = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
             (state_d == S_DATA_LO) || (state_d == S_DATA_HI) ||
             (state_d == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SYNC;
      rx_rd_q       <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_waddr_q   <= '0;
      ram_wdata_q   <= 16'h0000;
      core_resetq_q <= 1'b0;
      busy_q        <= 1'b0;
      len_lo_q      <= 8'h00;
      left_q        <= 16'h0000;
      cnt_q         <= '0;
      lo_q          <= 8'h00;
`ifdef LOADER_CSUM_EN
      csum_q        <= 8'h00;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rx_rd_q       <= rx_rd_d;
      ram_we_q      <= ram_we_d;
      ram_waddr_q   <= ram_waddr_d;
      ram_wdata_q   <= ram_wdata_d;
      core_resetq_q <= core_resetq_d;
      busy_q        <= busy_d;
      len_lo_q      <= len_lo_d;
      left_q        <= left_d;
      cnt_q         <= cnt_d;
      lo_q          <= lo_d;
`ifdef LOADER_CSUM_EN
      csum_q        <= csum_d;
      err_q         <= err_d;
`endif
    end
  end

  // Core address bits outside the word-address field are not used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{core_mem_addr[15:ADDR_W+1], core_mem_addr[0]};

  // Once released, the core drives the RAM port directly (no added latency).
  assign rx_rd       = rx_rd_q;
  assign ram_we      = core_resetq_q ? core_mem_wr                 : ram_we_q;
  assign ram_waddr   = core_resetq_q ? core_mem_addr[ADDR_W:1]     : ram_waddr_q;
  assign ram_wdata   = core_resetq_q ? core_dout                   : ram_wdata_q;
  assign core_resetq = core_resetq_q;
  assign busy        = busy_q;
`ifdef LOADER_CSUM_EN
  assign err         = err_q;
`else
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_j1a_boot_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for j1a_boot_arbiter: directed boot frames plus a vector table for
// the RUN-mode pass-through. Honours LOADER_CSUM_EN (appends checksum bytes).
// -----------------------------------------------------------------------------
module tb_j1a_boot_arbiter;
  localparam int ADDR_W = 12;
`ifdef LOADER_CSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_rd;
  logic              core_mem_wr = 1'b0;
  logic [15:0]       core_mem_addr = 16'h0000;
  logic [15:0]       core_dout = 16'h0000;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [15:0]       ram_wdata;
  logic              core_resetq;
  logic              busy;
  logic              err;

  always #5 clk = ~clk;

  j1a_boot_arbiter #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .core_mem_wr(core_mem_wr), .core_mem_addr(core_mem_addr), .core_dout(core_dout),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .core_resetq(core_resetq), .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- RX byte source and monitor ----------------
  logic [7:0] rx_buf [0:255];
  int  wr_ptr = 0;      // written only by the stimulus process
  int  rd_ptr = 0;      // written only by the monitor
  logic hold_valid = 1'b0;
  int  cyc = 0;
  int  rd_cnt = 0, last_rd_cyc = -1, last_wr_cyc = -1, run_rise_cyc = -1;
  logic prev_rq = 1'b0;
  logic [ADDR_W-1:0] wr_addr_log [$];
  logic [15:0]       wr_data_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_rd) begin
      rd_cnt++;
      last_rd_cyc = cyc;
      if (rd_ptr != wr_ptr) rd_ptr++;
    end
    if (ram_we && !core_resetq) begin
      wr_addr_log.push_back(ram_waddr);
      wr_data_log.push_back(ram_wdata);
      last_wr_cyc = cyc;
    end
    if (core_resetq && !prev_rq) run_rise_cyc = cyc;
    prev_rq  = core_resetq;
    rx_valid = hold_valid || (rd_ptr != wr_ptr);
    rx_data  = rx_buf[rd_ptr % 256];
  end

  // Stimulus acts 1 time unit after the rising edge, away from the monitor.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_buf[wr_ptr % 256] = b;
    wr_ptr++;
  endtask

  // Frame with nw words; data bytes packed LSB-first in d.
  task automatic push_frame(input logic [63:0] d, input int nw);
    logic [7:0] cs;
    cs = 8'h00;
    push(8'hA5);
    push(nw[7:0]);
    push(nw[15:8]);
    for (int i = 0; i < 2 * nw; i++) begin
      push(d[8*i +: 8]);
      cs = cs ^ d[8*i +: 8];
    end
    if (CSUM_BYTES == 1) push(cs);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold_valid = 1'b0;
    wr_ptr = rd_ptr;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_drain(input int extra);
    int k;
    k = 0;
    while (rd_ptr != wr_ptr && k < 400) begin
      tick();
      k++;
    end
    check("drain_timeout", 32'(rd_ptr == wr_ptr), 32'd1);
    repeat (extra) tick();
  endtask

  typedef struct {
    logic              wr;
    logic [15:0]       addr;
    logic [15:0]       dout;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_waddr;
    logic [15:0]       exp_wdata;
  } run_vec_t;

  run_vec_t vecs [5];

  int wb, rb;

  initial begin
    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 1'b1, 12'h008, 16'hBEEF};
    vecs[1] = '{1'b0, 16'h0010, 16'hBEEF, 1'b0, 12'h008, 16'hBEEF};
    vecs[2] = '{1'b1, 16'h1FFE, 16'h1234, 1'b1, 12'hFFF, 16'h1234};
    vecs[3] = '{1'b1, 16'h2002, 16'h5555, 1'b1, 12'h001, 16'h5555};
    vecs[4] = '{1'b1, 16'h0001, 16'hAAAA, 1'b1, 12'h000, 16'hAAAA};

    // ---- reset state ----
    do_reset();
    check("rst_rx_rd", 32'(rx_rd), 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_waddr", 32'(ram_waddr), 0);
    check("rst_ram_wdata", 32'(ram_wdata), 0);
    check("rst_core_resetq", 32'(core_resetq), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err), 0);

    // ---- 1: two-word frame ----
    wb = wr_addr_log.size(); rb = rd_cnt;
    push_frame(64'h0000_0000_5678_1234, 2);
    repeat (4) tick();
    check("t1_busy_mid", 32'(busy), 1);
    wait_drain(4);
    check("t1_nwr", 32'(wr_addr_log.size() - wb), 2);
    if (wr_addr_log.size() >= wb + 2) begin
      check("t1_a0", 32'(wr_addr_log[wb]), 0);
      check("t1_d0", 32'(wr_data_log[wb]), 32'h1234);
      check("t1_a1", 32'(wr_addr_log[wb+1]), 1);
      check("t1_d1", 32'(wr_data_log[wb+1]), 32'h5678);
    end
    check("t1_nrd", 32'(rd_cnt - rb), 32'(7 + CSUM_BYTES));
    check("t1_run_rise", 32'(run_rise_cyc), 32'(last_rd_cyc + 1));
`ifndef LOADER_CSUM_EN
    check("t1_wr_latency", 32'(last_wr_cyc), 32'(last_rd_cyc));
`endif
    check("t1_core_resetq", 32'(core_resetq), 1);
    check("t1_busy_end", 32'(busy), 0);

    // ---- 2: junk before sync ----
    do_reset();
    wb = wr_addr_log.size(); rb = rd_cnt;
    push(8'h00);
    push(8'hFF);
    push_frame(64'h0000_0000_0000_ABCD, 1);
    wait_drain(4);
    check("t2_nrd", 32'(rd_cnt - rb), 32'(7 + CSUM_BYTES));
    check("t2_nwr", 32'(wr_addr_log.size() - wb), 1);
    if (wr_addr_log.size() >= wb + 1) begin
      check("t2_a0", 32'(wr_addr_log[wb]), 0);
      check("t2_d0", 32'(wr_data_log[wb]), 32'hABCD);
    end
    check("t2_core_resetq", 32'(core_resetq), 1);

    // ---- 3: empty image ----
    do_reset();
    wb = wr_addr_log.size(); rb = rd_cnt;
    push_frame(64'h0, 0);
    wait_drain(4);
    check("t3_nwr", 32'(wr_addr_log.size() - wb), 0);
    check("t3_nrd", 32'(rd_cnt - rb), 32'(3 + CSUM_BYTES));
    check("t3_run_rise", 32'(run_rise_cyc), 32'(last_rd_cyc + 1));
    check("t3_core_resetq", 32'(core_resetq), 1);

    // ---- 4: RUN pass-through table, rx_valid held high ----
    hold_valid = 1'b1;
    rb = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      core_mem_wr   = vecs[i].wr;
      core_mem_addr = vecs[i].addr;
      core_dout     = vecs[i].dout;
      #1;
      check($sformatf("run%0d_we", i), 32'(ram_we), 32'(vecs[i].exp_we));
      check($sformatf("run%0d_waddr", i), 32'(ram_waddr), 32'(vecs[i].exp_waddr));
      check($sformatf("run%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].exp_wdata));
      check($sformatf("run%0d_rx_rd", i), 32'(rx_rd), 0);
      tick();
    end
    check("run_no_consume", 32'(rd_cnt - rb), 0);
    hold_valid = 1'b0;
    core_mem_wr = 1'b0;

    // ---- 5: reset mid-load, core write attempts ignored ----
    do_reset();
    core_mem_wr = 1'b1; core_mem_addr = 16'h0040; core_dout = 16'hDEAD;
    wb = wr_addr_log.size();
    push(8'hA5); push(8'h02); push(8'h00); push(8'h11); push(8'h22); push(8'h33);
    wait_drain(3);
    check("t5_nwr_partial", 32'(wr_addr_log.size() - wb), 1);
    if (wr_addr_log.size() >= wb + 1) begin
      check("t5_a0", 32'(wr_addr_log[wb]), 0);
      check("t5_d0", 32'(wr_data_log[wb]), 32'h2211);
    end
    check("t5_busy_partial", 32'(busy), 1);
    check("t5_core_resetq_partial", 32'(core_resetq), 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_core_resetq", 32'(core_resetq), 0);
    check("t5_rst_busy", 32'(busy), 0);
    check("t5_rst_ram_we", 32'(ram_we), 0);
    wb = wr_addr_log.size();
    push_frame(64'h0000_0000_5566_3344, 2);
    wait_drain(4);
    check("t5_nwr_full", 32'(wr_addr_log.size() - wb), 2);
    if (wr_addr_log.size() >= wb + 2) begin
      check("t5_fa0", 32'(wr_addr_log[wb]), 0);
      check("t5_fd0", 32'(wr_data_log[wb]), 32'h3344);
      check("t5_fa1", 32'(wr_addr_log[wb+1]), 1);
      check("t5_fd1", 32'(wr_data_log[wb+1]), 32'h5566);
    end
    check("t5_core_resetq", 32'(core_resetq), 1);
    core_mem_wr = 1'b0;

`ifdef LOADER_CSUM_EN
    // ---- 6: checksum match and mismatch ----
    do_reset();
    wb = wr_addr_log.size();
    push(8'hA5); push(8'h01); push(8'h00); push(8'h12); push(8'h34); push(8'h26);
    wait_drain(4);
    check("t6_nwr", 32'(wr_addr_log.size() - wb), 1);
    if (wr_addr_log.size() >= wb + 1) check("t6_d0", 32'(wr_data_log[wb]), 32'h3412);
    check("t6_core_resetq", 32'(core_resetq), 1);
    check("t6_err_ok", 32'(err), 0);
    do_reset();
    push(8'hA5); push(8'h01); push(8'h00); push(8'h12); push(8'h34); push(8'h27);
    wait_drain(4);
    check("t6_err_bad", 32'(err), 1);
    check("t6_core_resetq_bad", 32'(core_resetq), 0);
    rb = rd_cnt;
    push(8'h55);
    repeat (6) tick();
    check("t6_err_no_consume", 32'(rd_cnt - rb), 0);
    check("t6_err_ram_we", 32'(ram_we), 0);
    check("t6_err_sticky", 32'(err), 1);
    do_reset();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
